// File: rtl/alu_pkg.sv
// Shared encodings for the handshaked ALU: op codes, op field width and FSM states.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'd0;
    localparam logic [OP_W-1:0] OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [OP_W-1:0] OP_NOT = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ops 0-5 (logic, ADD, SUB) producing {cout,result}; purely combinational, no state.
// Optional signed-overflow output exists only when ALU_OVF_EN is defined.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] res,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // SUB as A + ~B + 1 so the carry out doubles as the no-borrow flag.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    always_comb begin
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_ADD: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_SUB: begin
                res  = diff[WIDTH-1:0];
                cout = diff[WIDTH];
            end
            default: begin
                res  = '0;
                cout = 1'b0;
            end
        endcase
    end

`ifdef ALU_OVF_EN
    always_comb begin
        ovf = 1'b0;
        if (op == OP_ADD)
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (op == OP_SUB)
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: ops 0-5 and zero-length shifts in 1 cycle, shifts by n in n+1 cycles; in_ready low
// while shifting and follows out_ready while a result is held. ALU_OVF_EN adds the registered ovf port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             neg
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             sh_cout_q, sh_cout_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] core_res;
    logic             core_cout;
    logic [SHW-1:0]   amt;
    logic             in_xfer;
    logic             load_res;
    logic [WIDTH-1:0] new_res;
    logic             new_cout;

`ifdef ALU_OVF_EN
    logic core_ovf;
    logic new_ovf;
    logic ovf_q, ovf_d;
`endif

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a    (a),
        .b    (b),
        .op   (op),
        .res  (core_res),
`ifdef ALU_OVF_EN
        .ovf  (core_ovf),
`endif
        .cout (core_cout)
    );

    assign amt       = b[SHW-1:0];
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign out_valid = (state_q == ST_HOLD);
    assign in_xfer   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        sh_cout_d = sh_cout_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        load_res  = 1'b0;
        new_res   = '0;
        new_cout  = 1'b0;
`ifdef ALU_OVF_EN
        ovf_d     = ovf_q;
        new_ovf   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (in_xfer) begin
                    if (is_shift_op(op) && (amt != '0)) begin
                        work_d    = a;
                        cnt_d     = amt;
                        dir_d     = (op == OP_SHR);
                        sh_cout_d = 1'b0;
                        state_d   = ST_SHIFT;
                    end else begin
                        load_res = 1'b1;
                        new_res  = is_shift_op(op) ? a : core_res;
                        new_cout = is_shift_op(op) ? 1'b0 : core_cout;
`ifdef ALU_OVF_EN
                        new_ovf  = core_ovf;
`endif
                        state_d  = ST_HOLD;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // n single-bit shifts, then one cycle to publish the working value.
                if (cnt_q != '0) begin
                    work_d    = dir_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
                    sh_cout_d = dir_q ? work_q[0] : work_q[WIDTH-1];
                    cnt_d     = cnt_q - SHW'(1);
                end else begin
                    load_res = 1'b1;
                    new_res  = work_q;
                    new_cout = sh_cout_q;
                    state_d  = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_res) begin
            result_d = new_res;
            cout_d   = new_cout;
            zero_d   = (new_res == '0);
            neg_d    = new_res[WIDTH-1];
`ifdef ALU_OVF_EN
            ovf_d    = new_ovf;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sh_cout_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sh_cout_q <= sh_cout_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
        end
    end

`ifdef ALU_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign neg    = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); ovf vectors run when ALU_OVF_EN is defined.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] op = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic       neg;
`ifdef ALU_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .neg       (neg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one accept edge; returns 1 time unit after that edge.
    task automatic issue(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb);
        op = o;
        a = va;
        b = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] exp_logic [4];
    logic       exp_neg   [4];

    initial begin
        exp_logic[0] = 8'h05; exp_neg[0] = 1'b0;
        exp_logic[1] = 8'h0F; exp_neg[1] = 1'b0;
        exp_logic[2] = 8'h0A; exp_neg[2] = 1'b0;
        exp_logic[3] = 8'hF0; exp_neg[3] = 1'b1;

        step();
        step();
        check1("rst_out_valid", out_valid, 1'b0);
        check8("rst_result", result, 8'h00);
        check1("rst_cout", cout, 1'b0);
        check1("rst_zero", zero, 1'b0);
        check1("rst_neg", neg, 1'b0);
        rst_n = 1'b1;
        step();
        check1("rst_in_ready", in_ready, 1'b1);

        // Logic ops back-to-back, one result per cycle.
        out_ready = 1'b1;
        a = 8'h0F;
        b = 8'h05;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 3'(i);
            step();
            check1($sformatf("logic%0d_valid", i), out_valid, 1'b1);
            check8($sformatf("logic%0d_result", i), result, exp_logic[i]);
            check1($sformatf("logic%0d_cout", i), cout, 1'b0);
            check1($sformatf("logic%0d_neg", i), neg, exp_neg[i]);
            check1($sformatf("logic%0d_in_ready", i), in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        check1("logic_drain_valid", out_valid, 1'b0);

        // Arithmetic.
        issue(3'd4, 8'hFF, 8'h01);
        check8("add_wrap_result", result, 8'h00);
        check1("add_wrap_cout", cout, 1'b1);
        check1("add_wrap_zero", zero, 1'b1);
        check1("add_wrap_neg", neg, 1'b0);
        step();
        issue(3'd5, 8'h0F, 8'h05);
        check8("sub_pos_result", result, 8'h0A);
        check1("sub_pos_cout", cout, 1'b1);
        check1("sub_pos_zero", zero, 1'b0);
        step();
        issue(3'd5, 8'h05, 8'h0F);
        check8("sub_neg_result", result, 8'hF6);
        check1("sub_neg_cout", cout, 1'b0);
        check1("sub_neg_neg", neg, 1'b1);
        step();

        // SHL by 5: in_valid held during SHIFT must be refused without corrupting the result.
        issue(3'd6, 8'h0F, 8'h05);
        out_ready = 1'b0;
        op = 3'd0;
        a = 8'hFF;
        b = 8'hFF;
        in_valid = 1'b1;
        check1("shl_c0_valid", out_valid, 1'b0);
        check1("shl_c0_in_ready", in_ready, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check1($sformatf("shl_c%0d_valid", k), out_valid, 1'b0);
            check1($sformatf("shl_c%0d_in_ready", k), in_ready, 1'b0);
        end
        step();
        check1("shl_c6_valid", out_valid, 1'b1);
        check8("shl_result", result, 8'hE0);
        check1("shl_cout", cout, 1'b1);
        check1("shl_neg", neg, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check1("shl_drain_valid", out_valid, 1'b0);

        issue(3'd7, 8'h0F, 8'h00);
        check1("shr0_valid", out_valid, 1'b1);
        check8("shr0_result", result, 8'h0F);
        check1("shr0_cout", cout, 1'b0);
        step();

        // Backpressure in HOLD, then simultaneous output and input transfer.
        out_ready = 1'b0;
        issue(3'd4, 8'h30, 8'h12);
        for (int k = 0; k < 4; k++) begin
            step();
            check1($sformatf("bp%0d_valid", k), out_valid, 1'b1);
            check8($sformatf("bp%0d_result", k), result, 8'h42);
            check1($sformatf("bp%0d_cout", k), cout, 1'b0);
            check1($sformatf("bp%0d_in_ready", k), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        op = 3'd2;
        a = 8'hFF;
        b = 8'h0F;
        in_valid = 1'b1;
        #1;
        check1("b2b_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check1("b2b_valid", out_valid, 1'b1);
        check8("b2b_result", result, 8'hF0);
        step();
        check1("b2b_drain_valid", out_valid, 1'b0);

        // Reset asserted mid-SHIFT.
        issue(3'd6, 8'h01, 8'h07);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check1("arst_valid", out_valid, 1'b0);
        check8("arst_result", result, 8'h00);
        check1("arst_neg", neg, 1'b0);
        check1("arst_cout", cout, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check1($sformatf("post_rst%0d_valid", k), out_valid, 1'b0);
        end
        check1("post_rst_in_ready", in_ready, 1'b1);

`ifdef ALU_OVF_EN
        issue(3'd4, 8'h7F, 8'h01);
        check8("ovf_add_result", result, 8'h80);
        check1("ovf_add", ovf, 1'b1);
        step();
        issue(3'd5, 8'h80, 8'h01);
        check8("ovf_sub_result", result, 8'h7F);
        check1("ovf_sub", ovf, 1'b1);
        step();
        issue(3'd0, 8'hFF, 8'hFF);
        check8("ovf_and_result", result, 8'hFF);
        check1("ovf_and", ovf, 1'b0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
